// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the temperature read scheduler and the I2C reader wrapper.
//  - state_t: scheduler FSM encoding
//  - DEF_*: default timing and alarm constants
//  - READER_FRAME_TICKS: clk_200kHz cycles in one complete reader frame
package temp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  localparam int unsigned DEF_PERIOD_TICKS   = 200000;
  localparam int unsigned DEF_TIMEOUT_TICKS  = 1024;
  localparam int unsigned DEF_AVG_LOG2       = 2;
  localparam logic [7:0]  DEF_ALARM_HI       = 8'd30;
  localparam logic [7:0]  DEF_ALARM_LO       = 8'd28;
  localparam int unsigned READER_FRAME_TICKS = 560;

endpackage

// File: rtl/temp_avg_window.sv
// Moving-average window over the last 2^AVG_LOG2 temperature samples.
// The first push after reset fills every entry, so the first average equals
// that sample. avg_next_c is the rounded average the window holds once the
// current sample is pushed, so it can be registered on the push edge.
// Ports:
//  clk_200kHz  in   system clock
//  reset_n     in   asynchronous active-low reset (window marked empty)
//  push        in   write sample into the window this cycle
//  sample      in   8-bit temperature code
//  avg_next_c  out  rounded average including sample (combinational)
module temp_avg_window
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic       clk_200kHz,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] sample,
  output logic [7:0] avg_next_c
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SUM_W = 8 + AVG_LOG2;

  logic [7:0]          win_q [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_next_c;
  logic [SUM_W-1:0]    rounded_c;
  logic                filled;

  // Running sum after this push; wr_ptr always points at the oldest entry.
  always_comb begin
    if (!filled) begin
      sum_next_c = SUM_W'(sample) << AVG_LOG2;
    end else begin
      sum_next_c = sum_q - SUM_W'(win_q[wr_ptr]) + SUM_W'(sample);
    end
    rounded_c  = sum_next_c + SUM_W'(1 << (AVG_LOG2 - 1));
    avg_next_c = 8'(rounded_c >> AVG_LOG2);
  end

  // Window storage, pointer and running sum.
  always_ff @(posedge clk_200kHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= '0;
      wr_ptr <= '0;
      sum_q  <= '0;
      filled <= 1'b0;
    end else if (push) begin
      sum_q  <= sum_next_c;
      filled <= 1'b1;
      wr_ptr <= wr_ptr + AVG_LOG2'(1);
      if (!filled) begin
        for (int unsigned i = 0; i < DEPTH; i++) win_q[i] <= sample;
      end else begin
        win_q[wr_ptr] <= sample;
      end
    end
  end

endmodule

// File: rtl/temp_read_scheduler.sv
// Sequences the I2C temperature reader: holds it in reset between samples,
// releases it once per period or on request, waits for a frame or times out,
// averages the readings and drives a hysteretic over-temperature alarm.
// Ports:
//  clk_200kHz   in   system clock
//  reset_n      in   asynchronous active-low reset
//  enable       in   1 = scheduling active, 0 = abort and idle
//  req          in   one-cycle on-demand sample request
//  ack          out  one-cycle pulse closing a request
//  rd_reset     out  active-high reader reset (1 = reader idle)
//  rd_done      in   reader frame complete, rd_temp valid
//  rd_temp      in   reader temperature code
//  temp         out  averaged temperature
//  temp_valid   out  one-cycle pulse when temp updates
//  alarm        out  over-temperature flag
//  err_timeout  out  one-cycle pulse on acquisition timeout
//  err_count    out  saturating timeout count
module temp_read_scheduler
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS  = DEF_PERIOD_TICKS,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int unsigned AVG_LOG2      = DEF_AVG_LOG2,
  parameter logic [7:0]  ALARM_HI      = DEF_ALARM_HI,
  parameter logic [7:0]  ALARM_LO      = DEF_ALARM_LO
) (
  input  logic       clk_200kHz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       req,
  output logic       ack,
  output logic       rd_reset,
  input  logic       rd_done,
  input  logic [7:0] rd_temp,
  output logic [7:0] temp,
  output logic       temp_valid,
  output logic       alarm,
  output logic       err_timeout,
  output logic [7:0] err_count
);

  localparam int unsigned PW = $clog2(PERIOD_TICKS);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS);

  state_t        state_q, state_d;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          pending;
  logic [7:0]    sample_q;
  logic          trigger_c, tmo_last_c;
  logic          ack_d, temp_valid_d, err_tmo_d, rd_reset_d;
  logic          capture_c, push_c, report_c, timeout_c;
  logic [7:0]    avg_next_c;

  assign trigger_c  = enable && (period_cnt == PW'(PERIOD_TICKS - 1));
  assign tmo_last_c = (tmo_cnt == TW'(TIMEOUT_TICKS - 1));

  // State register.
  always_ff @(posedge clk_200kHz or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (trigger_c || pending) state_d = ST_ACQUIRE;
        ST_ACQUIRE: if (rd_done)              state_d = ST_ACCUM;
                    else if (tmo_last_c)      state_d = ST_IDLE;
        ST_ACCUM:   state_d = ST_REPORT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode; report outputs are registered on entry to REPORT so
  // temp_valid lands two cycles after rd_done.
  always_comb begin
    ack_d        = 1'b0;
    temp_valid_d = 1'b0;
    err_tmo_d    = 1'b0;
    capture_c    = 1'b0;
    push_c       = 1'b0;
    report_c     = 1'b0;
    timeout_c    = 1'b0;
    rd_reset_d   = (state_d != ST_ACQUIRE);
    if (!enable) begin
      ack_d = pending;
    end else begin
      case (state_q)
        ST_ACQUIRE: begin
          if (rd_done) begin
            capture_c = 1'b1;
          end else if (tmo_last_c) begin
            err_tmo_d = 1'b1;
            timeout_c = 1'b1;
            ack_d     = pending;
          end
        end
        ST_ACCUM: begin
          push_c       = 1'b1;
          report_c     = 1'b1;
          temp_valid_d = 1'b1;
          ack_d        = pending;
        end
        default: ;
      endcase
    end
  end

  // Counters, request latch and registered outputs.
  always_ff @(posedge clk_200kHz or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt  <= '0;
      tmo_cnt     <= '0;
      pending     <= 1'b0;
      sample_q    <= '0;
      ack         <= 1'b0;
      rd_reset    <= 1'b1;
      temp        <= '0;
      temp_valid  <= 1'b0;
      alarm       <= 1'b0;
      err_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      if (!enable || trigger_c) period_cnt <= '0;
      else                      period_cnt <= period_cnt + PW'(1);

      if (state_q == ST_ACQUIRE) tmo_cnt <= tmo_cnt + TW'(1);
      else                       tmo_cnt <= '0;

      // A new request wins over the ack that closes the previous one.
      if (req && enable) pending <= 1'b1;
      else if (ack_d)    pending <= 1'b0;

      if (capture_c) sample_q <= rd_temp;

      ack         <= ack_d;
      rd_reset    <= rd_reset_d;
      temp_valid  <= temp_valid_d;
      err_timeout <= err_tmo_d;

      if (report_c) begin
        temp <= avg_next_c;
        if (avg_next_c >= ALARM_HI)      alarm <= 1'b1;
        else if (avg_next_c <= ALARM_LO) alarm <= 1'b0;
      end

      if (timeout_c && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  temp_avg_window #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk_200kHz (clk_200kHz),
    .reset_n    (reset_n),
    .push       (push_c),
    .sample     (sample_q),
    .avg_next_c (avg_next_c)
  );

endmodule

// File: tb/tb_temp_read_scheduler.sv
// Directed bench for temp_read_scheduler: table-driven averaging/alarm vectors
// plus hand sequences for period, timeout, coincident trigger, abort and reset.
module tb_temp_read_scheduler;
  import temp_ctrl_pkg::*;

  localparam int unsigned PERIOD = 2000;
  localparam int unsigned TMO    = 1024;

  logic clk_200kHz = 1'b0;
  always #5 clk_200kHz = ~clk_200kHz;

  logic       reset_n, enable, req, rd_done;
  logic [7:0] rd_temp;
  logic       ack, rd_reset, temp_valid, alarm, err_timeout;
  logic [7:0] temp, err_count;

  logic       f_reset_n;
  logic       f_ack, f_rd_reset, f_temp_valid, f_alarm, f_err_timeout;
  logic [7:0] f_temp, f_err_count;

  int checks = 0;
  int errors = 0;
  int unsigned f_pulses = 0;

  typedef struct {
    logic [7:0] sample;
    logic [7:0] exp_temp;
    logic       exp_alarm;
  } vec_t;
  vec_t vecs [9];

  temp_read_scheduler #(
    .PERIOD_TICKS (PERIOD),
    .TIMEOUT_TICKS(TMO)
  ) u_dut (
    .clk_200kHz (clk_200kHz), .reset_n(reset_n), .enable(enable), .req(req),
    .ack(ack), .rd_reset(rd_reset), .rd_done(rd_done), .rd_temp(rd_temp),
    .temp(temp), .temp_valid(temp_valid), .alarm(alarm),
    .err_timeout(err_timeout), .err_count(err_count)
  );

  // Short period/timeout instance whose reader never answers: exercises saturation.
  temp_read_scheduler #(
    .PERIOD_TICKS (16),
    .TIMEOUT_TICKS(8)
  ) u_dut_fast (
    .clk_200kHz (clk_200kHz), .reset_n(f_reset_n), .enable(1'b1), .req(1'b0),
    .ack(f_ack), .rd_reset(f_rd_reset), .rd_done(1'b0), .rd_temp(8'd0),
    .temp(f_temp), .temp_valid(f_temp_valid), .alarm(f_alarm),
    .err_timeout(f_err_timeout), .err_count(f_err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_200kHz);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_rd_low(input int unsigned budget, output int unsigned n);
    n = 0;
    while (rd_reset !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Answer an open acquisition after lat cycles and check the report.
  task automatic reader_respond(input logic [7:0] val, input int unsigned lat,
                                input logic [7:0] exp_temp, input logic exp_alarm,
                                input logic exp_ack, input string tag);
    repeat (lat) tick();
    rd_temp = val;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check($sformatf("%s_tv_early", tag), temp_valid, 0);
    tick();
    check($sformatf("%s_tv", tag), temp_valid, 1);
    check($sformatf("%s_temp", tag), temp, exp_temp);
    check($sformatf("%s_alarm", tag), alarm, exp_alarm);
    check($sformatf("%s_ack", tag), ack, exp_ack);
    check($sformatf("%s_rd_reset", tag), rd_reset, 1);
    tick();
    check($sformatf("%s_tv_end", tag), temp_valid, 0);
  endtask

  // Saturation monitor on the fast instance.
  always @(negedge clk_200kHz) begin
    if (f_reset_n && f_err_timeout === 1'b1) begin
      f_pulses++;
      if (f_pulses == 1) begin
        check("f_cnt_first", f_err_count, 1);
        check("f_rd_reset_tmo", f_rd_reset, 1);
      end
      if (f_pulses == 255 || f_pulses == 256 || f_pulses == 300)
        check($sformatf("f_cnt_%0d", f_pulses), f_err_count, 255);
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int unsigned lows;
    reset_n = 1'b0; f_reset_n = 1'b0; enable = 1'b1; req = 1'b0;
    rd_done = 1'b0; rd_temp = 8'd0;
    vecs[0] = '{8'd24, 8'd24, 1'b0};
    vecs[1] = '{8'd26, 8'd25, 1'b0};
    vecs[2] = '{8'd28, 8'd26, 1'b0};
    vecs[3] = '{8'd30, 8'd27, 1'b0};
    vecs[4] = '{8'd32, 8'd29, 1'b0};
    vecs[5] = '{8'd32, 8'd31, 1'b1};
    vecs[6] = '{8'd32, 8'd32, 1'b1};
    vecs[7] = '{8'd20, 8'd29, 1'b1};
    vecs[8] = '{8'd28, 8'd28, 1'b0};
    tick(); tick();

    check("rst_rd_reset", rd_reset, 1);
    check("rst_ack", ack, 0);
    check("rst_temp", temp, 0);
    check("rst_temp_valid", temp_valid, 0);
    check("rst_alarm", alarm, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_count", err_count, 0);
    reset_n = 1'b1; f_reset_n = 1'b1;

    // Periodic sampling with a full-length reader frame.
    wait_rd_low(PERIOD + 10, n);
    check("t1_first_acq", rd_reset, 0);
    reader_respond(8'd25, READER_FRAME_TICKS, 8'd25, 1'b0, 1'b0, "t1a");
    wait_rd_low(PERIOD, n);
    check("t1_period", READER_FRAME_TICKS + 3 + n, PERIOD);
    reader_respond(8'd25, READER_FRAME_TICKS, 8'd25, 1'b0, 1'b0, "t1b");

    // Averaging and alarm hysteresis from an empty window.
    reset_n = 1'b0;
    tick();
    check("t2_rst_temp", temp, 0);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      pulse_req();
      wait_rd_low(4, n);
      check($sformatf("vec%0d_acq", i), rd_reset, 0);
      reader_respond(vecs[i].sample, 10, vecs[i].exp_temp, vecs[i].exp_alarm, 1'b1,
                     $sformatf("vec%0d", i));
    end

    // Timeout with a pending request.
    pulse_req();
    wait_rd_low(4, n);
    check("t4_acq", rd_reset, 0);
    n = 0;
    while (err_timeout !== 1'b1 && n < TMO + 50) begin
      tick();
      n++;
    end
    check("t4_tmo_cycle", n, TMO);
    check("t4_err_count", err_count, 1);
    check("t4_temp_kept", temp, 28);
    check("t4_ack", ack, 1);
    check("t4_rd_reset", rd_reset, 1);
    check("t4_tv", temp_valid, 0);
    tick();
    check("t4_tmo_pulse_end", err_timeout, 0);
    check("t4_ack_end", ack, 0);

    // Periodic sample, then a request coincident with the next trigger.
    wait_rd_low(PERIOD, n);
    check("t5_periodic_acq", rd_reset, 0);
    reader_respond(8'd28, READER_FRAME_TICKS, 8'd27, 1'b0, 1'b0, "t5p");
    repeat (PERIOD - 1 - (READER_FRAME_TICKS + 3)) tick();
    check("t5_idle_before", rd_reset, 1);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("t5_coinc_acq", rd_reset, 0);
    reader_respond(8'd28, 20, 8'd26, 1'b0, 1'b1, "t5c");
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd_reset !== 1'b1 || ack !== 1'b0) lows++;
    end
    check("t5_single_acq", lows, 0);

    // Enable dropped mid-acquisition with a pending request.
    pulse_req();
    wait_rd_low(4, n);
    check("t6_acq", rd_reset, 0);
    repeat (5) tick();
    enable = 1'b0;
    tick();
    check("t6_abort_rd_reset", rd_reset, 1);
    check("t6_abort_ack", ack, 1);
    check("t6_abort_tv", temp_valid, 0);
    check("t6_abort_temp", temp, 26);
    check("t6_abort_err_count", err_count, 1);
    tick();
    check("t6_abort_ack_end", ack, 0);
    rd_temp = 8'd99;
    rd_done = 1'b1;
    pulse_req();
    rd_done = 1'b0;
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (temp_valid !== 1'b0) lows++;
    end
    check("t6_rd_done_ignored", lows, 0);
    enable = 1'b1;
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_reset !== 1'b1) lows++;
    end
    check("t6_req_while_disabled_dropped", lows, 0);

    // Reset pulsed in ACCUM, then the window must start empty again.
    pulse_req();
    wait_rd_low(4, n);
    check("t6_acq2", rd_reset, 0);
    repeat (10) tick();
    rd_temp = 8'd40;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_rst_rd_reset", rd_reset, 1);
    check("t6_rst_temp", temp, 0);
    check("t6_rst_tv", temp_valid, 0);
    check("t6_rst_err_count", err_count, 0);
    check("t6_rst_ack", ack, 0);
    check("t6_rst_alarm", alarm, 0);
    tick();
    check("t6_rst_tv_held", temp_valid, 0);
    reset_n = 1'b1;
    tick();
    pulse_req();
    wait_rd_low(4, n);
    check("t6_acq3", rd_reset, 0);
    reader_respond(8'd10, 10, 8'd10, 1'b0, 1'b1, "t6r");

    // Saturation on the fast instance.
    n = 0;
    while (f_pulses < 300 && n < 6000) begin
      tick();
      n++;
    end
    check("f_pulses_seen", (f_pulses >= 300) ? 1 : 0, 1);
    check("f_err_count_sat", f_err_count, 255);
    check("f_temp", f_temp, 0);
    check("f_temp_valid", f_temp_valid, 0);
    check("f_ack", f_ack, 0);
    check("f_alarm", f_alarm, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
